ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Parametrised N-digit seven-segment scan driver; successor to the fixed 4-digit scan/decode logic in the board top level.
- Adds a configurable digit count and scan rate, per-digit enable and decimal point, and frame-synchronised double buffering (no tearing).
- Adds PWM brightness, inter-digit dead time and anode/cathode polarity selection.
- Sits between game logic (score, lives, state) and the board An*/Ca..Dp pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- SCAN_DIV_BITS, 18, prescaler width; dwell per digit = 2^SCAN_DIV_BITS clocks; must be >= 4.
- ANODE_ACTIVE_LOW, 1, 1 = anode driven 0 when lit.
- CATHODE_ACTIVE_LOW, 1, 1 = segment driven 0 when lit.

Ports:
- ClkPort  in  1  system clock (100 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i], digit 0 rightmost.
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown; 0 = blank.
- load  in  1  capture digits/dp/digit_en into the pending buffer.
- brightness  in  4  duty = (brightness+1)/16 of each dwell.
- anodes  out  NUM_DIGITS  digit selects, polarity per ANODE_ACTIVE_LOW.
- cathodes  out  8  {a,b,c,d,e,f,g,dp}, polarity per CATHODE_ACTIVE_LOW.
- scan_idx  out  ceil(log2(NUM_DIGITS))  digit currently driven.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clock and reset: one clock, ClkPort. Reset_n is asynchronous and active-low.
- Reset values:
  - prescaler = 0, scan_idx = 0, frame_tick = 0.
  - pending and active buffers all 0, so digit_en = 0 and the display is blank.
  - anodes all inactive; cathodes all segments off.
- Prescaler: free-running, SCAN_DIV_BITS wide, increments every clock.
- Digit advance: on wrap (all ones -> 0), scan_idx <= (scan_idx == NUM_DIGITS-1) ? 0 : scan_idx+1. Non-power-of-2 NUM_DIGITS wraps at NUM_DIGITS-1.
- Frame boundary: the wrap cycle where scan_idx goes NUM_DIGITS-1 -> 0. frame_tick = 1 on the following cycle, aligned with scan_idx = 0.
- Double buffer:
  - load = 1 captures the inputs into pending on that clock. Last load before the boundary wins.
  - At a frame boundary, active <= pending.
  - load coincident with the boundary: active takes the load-cycle inputs directly, and pending also captures them.
  - No load during a frame: active is unchanged.
- Decode: active nibble for scan_idx maps to the standard hex font.
  - Logical segments lit per nibble: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 all, 9 abcdfg.
  - A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
  - dp segment = active dp[scan_idx].
  - Disabled digit: all segments off, dp included.
- Output gating: anodes[scan_idx] is lit only when both hold:
  - prescaler != 0 (one-cycle dead time at each digit change);
  - prescaler[SCAN_DIV_BITS-1 -: 4] <= brightness.
  - All other anodes are inactive.
- Registering: anodes and cathodes are registered; one-cycle latency from prescaler/scan_idx to the pins. Cathodes never change while an anode is lit.
- Polarity parameters invert the registered outputs only; internal logic is active-high.
- Brightness is sampled every cycle; a change takes effect on the next cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. On release, scanning restarts at digit 0 with a blank display until the next load and frame boundary.

Optional Feature:
- Macro SSD_LEADING_ZERO_BLANK_EN.
- Defined: a digit is treated as disabled when both hold:
  - its nibble is 0;
  - every higher-index enabled digit is also 0 or disabled.
  - Digit 0 is never suppressed. dp on a suppressed digit still lights if set.
- Undefined: visibility is set by digit_en alone.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV_BITS=4, brightness=15: load digits=16'h1A3F, dp=0, en=4'hF.
  - After the next frame boundary, digits 0..3 show F,3,A,1, each for 15 lit + 1 dead cycles.
  - Active-low pins: digit 0 cathodes = 8'b01110001, digit 1 = 8'b00001101.
- Tearing: issue load mid-frame with new digits.
  - The current frame completes with the old values; the new values appear exactly at the cycle after frame_tick.
  - load on the boundary cycle is applied immediately.
- brightness=0: each digit's anode is lit for cycle 0 only, and blanked by dead time.
  - Net duty 0 lit cycles; with SCAN_DIV_BITS=6, lit cycles 1..3 of 64.
- NUM_DIGITS=3: scan_idx sequence is 0,1,2,0; frame_tick period = 3*16 clocks.
- Pull Reset_n low at digit 2 mid-dwell: anodes go inactive and cathodes off asynchronously.
  - After release, display blank until load and frame boundary.
- With SSD_LEADING_ZERO_BLANK_EN, digits=16'h0030: digits 3 and 2 blank, digits 1 and 0 show 3 and 0.
  - digits=16'h0000: only digit 0 shows 0.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver: double-buffered frame, PWM, dead time.
// Optional leading-zero blanking: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
  parameter int NUM_DIGITS         = 8,
  parameter int SCAN_DIV_BITS      = 18,
  parameter bit ANODE_ACTIVE_LOW   = 1'b1,
  parameter bit CATHODE_ACTIVE_LOW = 1'b1
) (
  input  logic                          ClkPort,
  input  logic                          Reset_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         anodes,
  output logic [7:0]                    cathodes,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] pre;
  logic [DW-1:0]            pend_dig;
  logic [DW-1:0]            act_dig;
  logic [NUM_DIGITS-1:0]    pend_dp;
  logic [NUM_DIGITS-1:0]    act_dp;
  logic [NUM_DIGITS-1:0]    pend_en;
  logic [NUM_DIGITS-1:0]    act_en;
  logic [NUM_DIGITS-1:0]    vis;
  logic [NUM_DIGITS-1:0]    an_d;
  logic [NUM_DIGITS-1:0]    an_q;
  logic [7:0]               seg_d;
  logic [7:0]               seg_q;
  logic                     wrap;
  logic                     boundary;
  logic                     lit;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign wrap     = &pre;
  assign boundary = wrap && (scan_idx == LAST);
  // pre == 0 is the dead cycle that hides the cathode change
  assign lit = (pre != '0) &&
               (pre[SCAN_DIV_BITS-1 -: 4] <= brightness);

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      pre        <= '0;
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= pre + 1'b1;
      frame_tick <= boundary;
      if (wrap)
        scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits;
        pend_dp  <= dp;
        pend_en  <= digit_en;
      end
      if (boundary) begin
        act_dig <= load ? digits   : pend_dig;
        act_dp  <= load ? dp       : pend_dp;
        act_en  <= load ? digit_en : pend_en;
      end
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic lead;

  // lead stays set while every higher enabled digit is zero
  always_comb begin
    lead = 1'b1;
    vis  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      vis[i] = act_en[i] &
               ~(lead & (act_dig[4*i +: 4] == 4'd0) & (i != 0));
      if (act_en[i] && (act_dig[4*i +: 4] != 4'd0))
        lead = 1'b0;
    end
  end
`else
  assign vis = act_en;
`endif

  always_comb begin
    an_d  = '0;
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        an_d[i] = lit;
        seg_d   = {vis[i] ? font(act_dig[4*i +: 4]) : 7'd0,
                   act_en[i] & act_dp[i]};
      end
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      an_q  <= '0;
      seg_q <= '0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign anodes   = ANODE_ACTIVE_LOW   ? ~an_q  : an_q;
  assign cathodes = CATHODE_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: 4-digit active-low and
// 3-digit active-high instances with a 16-clock dwell.
module tb_ssd_scan_driver;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  e;
  } img_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ca;
    logic [1:0] si;
    logic       tk;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic [1:0]  scan_idx;
  logic        frame_tick;

  logic [11:0] digits3 = '0;
  logic [2:0]  dp3 = '0;
  logic [2:0]  en3 = '0;
  logic        load3 = 1'b0;
  logic [2:0]  an3;
  logic [7:0]  cath3;
  logic [1:0]  si3;
  logic        tick3;

  int   checks = 0;
  int   errors = 0;
  img_t act = '0;
  img_t pend = '0;
  exp_t sb[$];

  string font_s [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                         "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg",
                         "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV_BITS(4),
    .ANODE_ACTIVE_LOW(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) dut (
    .ClkPort(clk), .Reset_n(Reset_n), .digits(digits),
    .dp(dp), .digit_en(digit_en), .load(load),
    .brightness(brightness), .anodes(anodes),
    .cathodes(cathodes), .scan_idx(scan_idx),
    .frame_tick(frame_tick)
  );

  ssd_scan_driver #(
    .NUM_DIGITS(3), .SCAN_DIV_BITS(4),
    .ANODE_ACTIVE_LOW(1'b0), .CATHODE_ACTIVE_LOW(1'b0)
  ) dut3 (
    .ClkPort(clk), .Reset_n(Reset_n), .digits(digits3),
    .dp(dp3), .digit_en(en3), .load(load3),
    .brightness(brightness), .anodes(an3),
    .cathodes(cath3), .scan_idx(si3),
    .frame_tick(tick3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] segs(input logic [3:0] n);
    string s;
    logic [6:0] r;
    int idx;
    s = font_s[n];
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      idx = int'(s.getc(i)) - 97;
      r[6-idx] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [3:0] vis_of(input img_t m);
    logic [3:0] v;
    v = m.e;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 4; i++) begin
      logic hz;
      hz = 1'b1;
      for (int j = i + 1; j < 4; j++)
        if (m.e[j] && m.d[4*j +: 4] != 4'd0) hz = 1'b0;
      if (m.d[4*i +: 4] == 4'd0 && hz) v[i] = 1'b0;
    end
`endif
    return v;
  endfunction

  task automatic drive(input img_t v);
    load     = 1'b1;
    digits   = v.d;
    dp       = v.p;
    digit_en = v.e;
    pend     = v;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 500);
    chk("tick_seen", frame_tick, 1);
  endtask

  // Entered on the frame_tick cycle; ends on the next one.
  task automatic check_frame(input int br,
                             input int c1, input img_t v1,
                             input int c2, input img_t v2);
    exp_t e;
    logic [3:0] v;
    logic [3:0] oh;
    int k, d, p;
    brightness = 4'(br);
    v = vis_of(act);
    for (int c = 1; c <= 64; c++) begin
      k = c - 1;
      d = k / 16;
      p = k % 16;
      oh = 4'b0001 << d;
      e.an = (p != 0 && p <= br) ? ~oh : 4'hF;
      e.ca = ~{v[d] ? segs(act.d[4*d +: 4]) : 7'd0,
               act.e[d] & act.p[d]};
      e.si = 2'((c / 16) % 4);
      e.tk = (c == 64);
      sb.push_back(e);
    end
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk("anodes", anodes, e.an);
      chk("cathodes", cathodes, e.ca);
      chk("scan_idx", scan_idx, e.si);
      chk("frame_tick", frame_tick, e.tk);
      load = 1'b0;
      if (c == c1) drive(v1);
      if (c == c2) drive(v2);
    end
    act = pend;
  endtask

  initial begin
    int n;
    img_t none;
    none = '0;
    repeat (3) @(negedge clk);
    chk("rst_anodes", anodes, 4'hF);
    chk("rst_cathodes", cathodes, 8'hFF);
    chk("rst_scan_idx", scan_idx, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_an3", an3, 0);
    chk("rst_cath3", cath3, 0);
    Reset_n = 1'b1;
    wait_tick(n);
    chk("first_tick_latency", n, 64);

    check_frame(15, 30, '{16'h1A3F, 4'h0, 4'hF}, 0, none);
    check_frame(15, 20, '{16'h5678, 4'b0101, 4'hF},
                63, '{16'hC0DE, 4'b1000, 4'b1011});
    check_frame(7, 0, none, 0, none);
    check_frame(0, 10, '{16'h0030, 4'b0100, 4'hF}, 0, none);
    check_frame(15, 63, '{16'h0000, 4'h0, 4'hF}, 0, none);
    check_frame(15, 0, none, 0, none);

    repeat (40) @(negedge clk);
    chk("pre_reset_idx", scan_idx, 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_anodes", anodes, 4'hF);
    chk("async_cathodes", cathodes, 8'hFF);
    chk("async_idx", scan_idx, 0);
    chk("async_an3", an3, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    act  = '0;
    pend = '0;
    wait_tick(n);
    chk("restart_latency", n, 64);
    check_frame(15, 0, none, 0, none);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick3 && n < 500);
    chk("tick3_seen", tick3, 1);
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      load3 = 1'b0;
      if (c == 10) begin
        load3   = 1'b1;
        digits3 = 12'h921;
        dp3     = 3'b010;
        en3     = 3'b111;
      end
      if (c == 16) chk("si3_1", si3, 1);
      if (c == 32) chk("si3_2", si3, 2);
      if (c == 47) chk("tick3_low", tick3, 0);
      if (c == 48) chk("tick3_period", tick3, 1);
      if (c == 48) chk("si3_wrap", si3, 0);
    end
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 6) chk("an3_d0", an3, 3'b001);
      if (c == 6) chk("cath3_d0", cath3, {segs(4'h1), 1'b0});
      if (c == 17) chk("an3_dead", an3, 3'b000);
      if (c == 22) chk("an3_d1", an3, 3'b010);
      if (c == 22) chk("cath3_d1", cath3, {segs(4'h2), 1'b1});
      if (c == 38) chk("an3_d2", an3, 3'b100);
      if (c == 38) chk("cath3_d2", cath3, {segs(4'h9), 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
